// File: rtl/rtl_ral_regbank.sv
// rtl_ral_regbank: parametrised register bank with RW, RO and W1C registers.
// A valid/ready request channel feeds a single-entry response register that
// supports back-to-back transactions and backpressure. Every request gets
// exactly one response. Out-of-range addresses and writes to RO registers
// raise the error flag.
module rtl_ral_regbank #(
  parameter int                   DATA_W    = 8,
  parameter int                   ADDR_W    = 3,
  parameter int                   NUM_REGS  = 8,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = {NUM_REGS{1'b0}},
  parameter logic [NUM_REGS-1:0]  W1C_MASK  = {NUM_REGS{1'b0}},
  parameter logic [DATA_W-1:0]    RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [ADDR_W-1:0]            add_i,
  input  logic [DATA_W-1:0]            dt_i,
  input  logic                         r_w_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [DATA_W-1:0]            dt_o,
  output logic                         err_o,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_val_i,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_set_i,
  output logic [NUM_REGS*DATA_W-1:0]   reg_o
);

  // One extra bit so NUM_REGS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_dt_r;
  logic              rsp_err_r;

  logic              accept_s;
  logic              wr_s;
  logic              in_range_s;
  logic              ro_sel_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [DATA_W-1:0] rsp_dt_s;
  logic              rsp_err_s;
  logic [DATA_W-1:0] cur_s [NUM_REGS];

  // Slices of the hardware inputs that do not apply to a register's policy
  // are intentionally ignored.
  logic              unused_s;
  assign unused_s = ^{hw_val_i, hw_set_i};

  // Ready whenever the response slot is empty or is being drained this edge.
  assign req_ready_o = ~rsp_valid_r | rsp_ready_i;
  assign accept_s    = req_valid_i & req_ready_o;
  assign wr_s        = accept_s & r_w_i;
  assign in_range_s  = ({1'b0, add_i} < NUM_REGS_L);

  assign rsp_valid_o = rsp_valid_r;
  assign dt_o        = rsp_dt_r;
  assign err_o       = rsp_err_r;

  // Read mux and RO-target decode as an AND-OR over implemented registers.
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    ro_sel_s  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_data_s = rd_data_s | (cur_s[i] & {DATA_W{add_i == ADDR_W'(i)}});
      ro_sel_s  = ro_sel_s | (RO_MASK[i] & (add_i == ADDR_W'(i)));
    end
  end

  // Response payload for the request presented this cycle.
  always_comb begin
    rsp_dt_s  = {DATA_W{1'b0}};
    rsp_err_s = 1'b0;
    if (!in_range_s) begin
      rsp_dt_s  = {DATA_W{1'b0}};
      rsp_err_s = 1'b1;
    end else if (r_w_i) begin
      rsp_dt_s  = {DATA_W{1'b0}};
      rsp_err_s = ro_sel_s;
    end else begin
      rsp_dt_s  = rd_data_s;
      rsp_err_s = 1'b0;
    end
  end

  // Single-entry response register: load on accept, drain on rsp_ready_i.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_dt_r    <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_dt_r    <= rsp_dt_s;
      rsp_err_r   <= rsp_err_s;
    end else if (rsp_ready_i) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  // Per-register storage; the access policy is fixed at elaboration.
  // RO takes precedence over W1C when both mask bits are set.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (RO_MASK[gi]) begin : g_ro
      assign cur_s[gi] = hw_val_i[gi*DATA_W +: DATA_W];
    end else if (W1C_MASK[gi]) begin : g_w1c
      logic              wr_hit_s;
      logic [DATA_W-1:0] val_r;
      assign wr_hit_s = wr_s & (add_i == ADDR_W'(gi));
      // Sticky status: hardware sets every cycle, bus clears with 1s; set wins.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          val_r <= {DATA_W{1'b0}};
        end else if (wr_hit_s) begin
          val_r <= (val_r & ~dt_i) | hw_set_i[gi*DATA_W +: DATA_W];
        end else begin
          val_r <= val_r | hw_set_i[gi*DATA_W +: DATA_W];
        end
      end
      assign cur_s[gi] = val_r;
    end else begin : g_rw
      logic              wr_hit_s;
      logic [DATA_W-1:0] val_r;
      assign wr_hit_s = wr_s & (add_i == ADDR_W'(gi));
      // Plain read/write control register.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          val_r <= RESET_VAL;
        end else if (wr_hit_s) begin
          val_r <= dt_i;
        end else begin
          val_r <= val_r;
        end
      end
      assign cur_s[gi] = val_r;
    end
    assign reg_o[gi*DATA_W +: DATA_W] = cur_s[gi];
  end

endmodule

// File: tb/tb_rtl_ral_regbank.sv
// Bench for rtl_ral_regbank: two instances (8 and 6 registers, RO at 2,
// W1C at 4) share one request stream and are compared every cycle against an
// array-based model of the register-bank rules, plus literal expectations.
module tb_rtl_ral_regbank;

  localparam logic [7:0] RO_M  = 8'h04;
  localparam logic [7:0] W1C_M = 8'h10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [2:0]  addr;
  logic [7:0]  wdata;
  logic        r_w;
  logic        rsp_ready;
  logic [63:0] hw_val;
  logic [63:0] hw_set;

  logic        req_ready_a, rsp_valid_a, err_a;
  logic [7:0]  dt_a;
  logic [63:0] reg_o_a;
  logic        req_ready_b, rsp_valid_b, err_b;
  logic [7:0]  dt_b;
  logic [47:0] reg_o_b;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  // Model state: register contents and the held response, per instance.
  logic [7:0] m_reg [2][8];
  logic       m_vld [2];
  logic [7:0] m_dt  [2];
  logic       m_err [2];

  always #5 clk = ~clk;

  rtl_ral_regbank #(
    .DATA_W(8), .ADDR_W(3), .NUM_REGS(8),
    .RO_MASK(8'h04), .W1C_MASK(8'h10), .RESET_VAL(8'h00)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_a),
    .add_i(addr), .dt_i(wdata), .r_w_i(r_w),
    .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready),
    .dt_o(dt_a), .err_o(err_a),
    .hw_val_i(hw_val), .hw_set_i(hw_set), .reg_o(reg_o_a)
  );

  rtl_ral_regbank #(
    .DATA_W(8), .ADDR_W(3), .NUM_REGS(6),
    .RO_MASK(6'h04), .W1C_MASK(6'h10), .RESET_VAL(8'h00)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_b),
    .add_i(addr), .dt_i(wdata), .r_w_i(r_w),
    .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready),
    .dt_o(dt_b), .err_o(err_b),
    .hw_val_i(hw_val[47:0]), .hw_set_i(hw_set[47:0]), .reg_o(reg_o_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int nregs(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  // Expected register view: RO slots show hw_val live, others the model array.
  function automatic logic [63:0] exp_regs(input int k);
    logic [63:0] v;
    v = 64'h0;
    for (int i = 0; i < nregs(k); i++) begin
      v[i*8 +: 8] = RO_M[i] ? hw_val[i*8 +: 8] : m_reg[k][i];
    end
    return v;
  endfunction

  // Behavioural model: advance register contents and response slot each edge.
  always @(posedge clk) begin : model
    logic       acc_v;
    int         a_v;
    logic [7:0] nv;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) m_reg[k][i] <= 8'h00;
        m_vld[k] <= 1'b0;
        m_dt[k]  <= 8'h00;
        m_err[k] <= 1'b0;
      end else begin
        acc_v = req_valid && (!m_vld[k] || rsp_ready);
        a_v   = int'(addr);
        for (int i = 0; i < nregs(k); i++) begin
          if (W1C_M[i] && !RO_M[i]) begin
            nv = m_reg[k][i];
            if (acc_v && r_w && a_v == i) nv = nv & ~wdata;
            m_reg[k][i] <= nv | hw_set[i*8 +: 8];
          end
        end
        if (acc_v) begin
          m_vld[k] <= 1'b1;
          if (a_v >= nregs(k)) begin
            m_dt[k] <= 8'h00; m_err[k] <= 1'b1;
          end else if (!r_w) begin
            m_dt[k]  <= RO_M[a_v] ? hw_val[a_v*8 +: 8] : m_reg[k][a_v];
            m_err[k] <= 1'b0;
          end else if (RO_M[a_v]) begin
            m_dt[k] <= 8'h00; m_err[k] <= 1'b1;
          end else begin
            m_dt[k] <= 8'h00; m_err[k] <= 1'b0;
            if (!W1C_M[a_v]) m_reg[k][a_v] <= wdata;
          end
        end else if (rsp_ready) begin
          m_vld[k] <= 1'b0;
        end
      end
    end
  end

  // Compare both instances against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a rsp_valid", {63'h0, rsp_valid_a}, {63'h0, m_vld[0]});
      chk("a dt",        {56'h0, dt_a},        {56'h0, m_dt[0]});
      chk("a err",       {63'h0, err_a},       {63'h0, m_err[0]});
      chk("a req_ready", {63'h0, req_ready_a}, {63'h0, (!m_vld[0] || rsp_ready)});
      chk("a reg_o",     reg_o_a,              exp_regs(0));
      chk("b rsp_valid", {63'h0, rsp_valid_b}, {63'h0, m_vld[1]});
      chk("b dt",        {56'h0, dt_b},        {56'h0, m_dt[1]});
      chk("b err",       {63'h0, err_b},       {63'h0, m_err[1]});
      chk("b req_ready", {63'h0, req_ready_b}, {63'h0, (!m_vld[1] || rsp_ready)});
      chk("b reg_o",     {16'h0, reg_o_b},     exp_regs(1));
    end
  end

  task automatic drive(input logic v, input logic [2:0] a, input logic [7:0] d,
                       input logic w, input logic rr);
    req_valid = v; addr = a; wdata = d; r_w = w; rsp_ready = rr;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; addr = 3'd0; wdata = 8'h00; r_w = 1'b0;
    rsp_ready = 1'b1; hw_val = 64'h0; hw_set = 64'h0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    rst_n = 1'b1;
    chk("reset rsp_valid", {63'h0, rsp_valid_a}, 64'h0);
    chk("reset req_ready", {63'h0, req_ready_a}, 64'h1);
    chk("reset reg_o",     reg_o_a,              64'h0);

    // Read every register after reset.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 8'h00, 1'b0, 1'b1);
      chk("rd dflt valid", {63'h0, rsp_valid_a}, 64'h1);
      chk("rd dflt dt",    {56'h0, dt_a},        64'h0);
      chk("rd dflt err",   {63'h0, err_a},       64'h0);
      chk("rd dflt ready", {63'h0, req_ready_a}, 64'h1);
    end
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);

    // Write then read-after-write on an RW register.
    drive(1'b1, 3'd3, 8'hA5, 1'b1, 1'b1);
    chk("wr rw dt",    {56'h0, dt_a},   64'h0);
    chk("wr rw err",   {63'h0, err_a},  64'h0);
    chk("wr rw reg3",  {56'h0, reg_o_a[31:24]}, 64'hA5);
    drive(1'b1, 3'd3, 8'h00, 1'b0, 1'b1);
    chk("raw dt",      {56'h0, dt_a},   64'hA5);

    // RO register: write rejected, read returns hw_val.
    hw_val[23:16] = 8'h3C;
    drive(1'b1, 3'd2, 8'hFF, 1'b1, 1'b1);
    chk("wr ro err",   {63'h0, err_a},  64'h1);
    chk("wr ro dt",    {56'h0, dt_a},   64'h0);
    chk("wr ro reg2",  {56'h0, reg_o_a[23:16]}, 64'h3C);
    drive(1'b1, 3'd2, 8'h00, 1'b0, 1'b1);
    chk("rd ro dt",    {56'h0, dt_a},   64'h3C);
    chk("rd ro err",   {63'h0, err_a},  64'h0);

    // W1C register: set pulse, set-wins collision, then a clear.
    hw_set[39:32] = 8'h81;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    hw_set[39:32] = 8'h00;
    chk("w1c set",     {56'h0, reg_o_a[39:32]}, 64'h81);
    drive(1'b1, 3'd4, 8'h00, 1'b0, 1'b1);
    chk("w1c rd",      {56'h0, dt_a},   64'h81);
    hw_set[39:32] = 8'h01;
    drive(1'b1, 3'd4, 8'h01, 1'b1, 1'b1);
    hw_set[39:32] = 8'h00;
    chk("w1c setwins", {56'h0, reg_o_a[39:32]}, 64'h81);
    drive(1'b1, 3'd4, 8'h80, 1'b1, 1'b1);
    chk("w1c clear",   {56'h0, reg_o_a[39:32]}, 64'h01);

    // Out-of-range on the 6-register instance.
    drive(1'b1, 3'd7, 8'h00, 1'b0, 1'b1);
    chk("oor rd valid", {63'h0, rsp_valid_b}, 64'h1);
    chk("oor rd dt",    {56'h0, dt_b},        64'h0);
    chk("oor rd err",   {63'h0, err_b},       64'h1);
    drive(1'b1, 3'd6, 8'hFF, 1'b1, 1'b1);
    chk("oor wr err",   {63'h0, err_b},       64'h1);
    chk("oor wr reg_o", {16'h0, reg_o_b},     64'h0001A53C0000);

    // Backpressure: hold a read response of 0xA5 for three cycles.
    drive(1'b1, 3'd3, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
      chk("stall ready", {63'h0, req_ready_a}, 64'h0);
      chk("stall dt",    {56'h0, dt_a},        64'hA5);
      chk("stall valid", {63'h0, rsp_valid_a}, 64'h1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("release ready", {63'h0, req_ready_a}, 64'h1);
    drive(1'b1, 3'd6, 8'h00, 1'b0, 1'b1);
    chk("release dt",    {56'h0, dt_a},        64'hFF);
    chk("release valid", {63'h0, rsp_valid_a}, 64'h1);

    // Reset in the middle of a stall drops the held response.
    drive(1'b1, 3'd3, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
    chk("pre-rst dt", {56'h0, dt_a}, 64'hA5);
    rst_n = 1'b0;
    drive(1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
    chk("rst valid", {63'h0, rsp_valid_a}, 64'h0);
    chk("rst dt",    {56'h0, dt_a},        64'h0);
    chk("rst reg3",  {56'h0, reg_o_a[31:24]}, 64'h0);
    chk("rst reg4",  {56'h0, reg_o_a[39:32]}, 64'h0);
    chk("rst reg6",  {56'h0, reg_o_a[55:48]}, 64'h0);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 3'd3, 8'h00, 1'b0, 1'b1);
    chk("post-rst rd", {56'h0, dt_a}, 64'h0);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rtl_ral_regbank.md
Name: rtl_ral_regbank

Overview:
- Parametrised next-generation register bank for the RAL test environment.
- Generalises the fixed 8x8 read/write bank in width, depth and per-register access policy: RW, RO (hardware-driven) and W1C (sticky status).
- Adds a valid/ready request/response handshake with backpressure and an error flag.
- Sits between a bus agent/driver and design status/control logic; the register model mirrors its contents.

Parameters:
DATA_W, 8, register and data-bus width in bits (>=1)
ADDR_W, 3, address width in bits
NUM_REGS, 8, number of implemented registers (1..2**ADDR_W)
RO_MASK, 0, NUM_REGS-bit vector; bit i=1 makes register i read-only, value taken from hw_val_i slice i
W1C_MASK, 0, NUM_REGS-bit vector; bit i=1 makes register i write-1-to-clear, set by hw_set_i slice i (RO_MASK takes precedence if both set)
RESET_VAL, 0, DATA_W-bit reset value of every RW register

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
req_valid_i  input  1  request valid
req_ready_o  output  1  request ready
add_i  input  ADDR_W  register address
dt_i  input  DATA_W  write data
r_w_i  input  1  0 = read, 1 = write
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response accepted by sink
dt_o  output  DATA_W  read data (0 for write responses)
err_o  output  1  response error flag
hw_val_i  input  NUM_REGS*DATA_W  hardware values for RO registers
hw_set_i  input  NUM_REGS*DATA_W  per-bit set pulses for W1C registers
reg_o  output  NUM_REGS*DATA_W  current contents of all registers (RO slices mirror hw_val_i)

Behaviour:
- Reset (rst_n low at a rising edge): RW regs <= RESET_VAL; W1C regs <= 0; rsp_valid_o, dt_o, err_o <= 0. Reset wins over any in-flight request or held response; the held response is dropped.
- req_ready_o = !rsp_valid_o || rsp_ready_i (combinational). Accept = req_valid_i && req_ready_o.
- Latency: a request accepted on edge N produces rsp_valid_o=1 with dt_o/err_o valid after edge N. The response is held stable until an edge with rsp_ready_i=1. A new accept on that same edge loads the next response back-to-back, giving 1 transaction per cycle with no bubbles.
- If rsp_ready_i=1 and there is no accept, rsp_valid_o <= 0; dt_o and err_o keep their last values.
- Every request, read or write, gets exactly one response.
- Read: dt_o <= register value sampled at the accept edge. For RO registers this is hw_val_i at that edge. err_o <= 0.
- Write to RW register: reg <= dt_i. dt_o <= 0, err_o <= 0.
- Write to W1C register: reg <= (reg & ~dt_i) | hw_set. If hw_set and a clear hit the same bit in the same cycle, set wins.
- Write to RO register: no state change, err_o <= 1, dt_o <= 0.
- Address >= NUM_REGS: read returns dt_o=0, err_o=1; write has no effect, err_o=1.
- W1C regs OR in hw_set_i every cycle, independent of bus activity.
- Read-after-write: write accepted at N, read of same address accepted at N+1 returns the new value.
- reg_o reflects register state after each edge. RO slices are a combinational pass-through of hw_val_i.

Test Plan:
- Reset then read all 8 regs (defaults, RESET_VAL=0) -> 8 responses, dt_o=0, err_o=0; req_ready_o=1 throughout with rsp_ready_i=1.
- Write 0xA5 to addr 3, next cycle read addr 3 -> write rsp dt_o=0/err_o=0, then read rsp dt_o=0xA5 one cycle after accept; reg_o slice 3 = 0xA5.
- RO_MASK=8'h04, hw_val_i slice 2=0x3C; write 0xFF to addr 2, then read addr 2 -> write rsp err_o=1, register unchanged; read rsp dt_o=0x3C, err_o=0.
- W1C_MASK=8'h10; pulse hw_set_i slice 4=0x81, read -> 0x81; write 0x01 while hw_set_i slice 4=0x01 -> reg stays 0x81 (set wins); write 0x80 -> reg 0x01.
- NUM_REGS=6; read addr 7 -> dt_o=0, err_o=1; write addr 6 -> err_o=1, reg_o unchanged.
- Hold rsp_ready_i=0 for 3 cycles after a read of 0xA5 with req_valid_i=1 -> req_ready_o=0, dt_o stays 0xA5; on release the next request is accepted the same edge. Assert rst_n=0 mid-stall -> rsp_valid_o=0 and regs at reset values next cycle.
